// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller driving an external 1-bit full-adder cell
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             fa_p,
    output logic             fa_q,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // Counter must hold WIDTH-1; keep at least one bit so WIDTH=1 still has a legal vector.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_s_next;

    // Next partial-sum value: shift right and insert the cell's sum bit at the MSB.
    // Written this way so WIDTH=1 needs no empty part-select.
    always_comb begin
        w_s_next            = r_s_sh >> 1;
        w_s_next[WIDTH-1]   = fa_sum;
    end

    // The operand shifters drain to zero by the end of RUN and the carry is cleared on
    // completion, so the cell drive lines read 0 in IDLE and DONE straight from registers.
    assign fa_p   = r_a_sh[0];
    assign fa_q   = r_b_sh[0];
    assign fa_cin = r_carry;
    assign busy   = r_busy;
    assign done   = r_done;
    assign sum    = r_sum;
    assign c_out  = r_c_out;

    // Control FSM with datapath: accept operands, stream one bit pair per cycle, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_s_sh <= w_s_next;
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    if (r_cnt == LAST_CNT) begin
                        r_sum   <= w_s_next;
                        r_c_out <= fa_cout;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_carry <= fa_cout;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that sits directly upstream of the team's 1-bit full-adder cell (inputs p, q, c_in; outputs sum, c_out). It accepts two WIDTH-bit operands and a carry-in, then feeds the cell one bit pair per cycle, LSB first. It routes the cell's carry-out back as the next carry-in and shifts the cell's sum bits into a result register. It then presents the full WIDTH-bit sum, the final carry and a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
c_in  input  1  initial carry-in; captured on the accepting edge
fa_p  output  1  bit to full-adder cell input p
fa_q  output  1  bit to full-adder cell input q
fa_cin  output  1  carry to full-adder cell input c_in
fa_sum  input  1  sum bit returned from the cell (combinational path)
fa_cout  input  1  carry returned from the cell (combinational path)
busy  output  1  high while an addition is in progress (RUN state)
done  output  1  one-cycle pulse when sum/c_out are updated
sum  output  WIDTH  registered result, held until the next completion
c_out  output  1  registered final carry, held until the next completion

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst has priority over everything.
  - On reset: state = IDLE; operand shift registers, carry register, bit counter, sum and c_out = 0; busy = 0; done = 0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - busy = 0, done = 0.
  - If start = 1 at an edge: A_sh <= a, B_sh <= b, carry <= c_in, cnt <= 0, state <= RUN.
- RUN:
  - busy = 1.
  - fa_p = A_sh[0], fa_q = B_sh[0], fa_cin = carry. These are driven from registers, so no combinational input-to-output path from a/b.
  - Each edge in RUN:
    - S_sh <= {fa_sum, S_sh[WIDTH-1:1]}
    - carry <= fa_cout
    - A_sh, B_sh shift right with zero fill
    - cnt <= cnt + 1
  - On the edge where cnt == WIDTH-1:
    - sum <= {fa_sum, S_sh[WIDTH-1:1]}
    - c_out <= fa_cout
    - state <= DONE
  - cnt is wide enough to hold WIDTH-1; it has no wrap behaviour beyond that value.
- DONE:
  - done = 1 for exactly one cycle; busy = 0.
  - Next edge returns unconditionally to IDLE.
- fa_p, fa_q and fa_cin are 0 in IDLE and DONE.
- Latency:
  - Start accepted at edge E0.
  - Bits are processed at edges E1..EWIDTH.
  - done is high during the cycle after EWIDTH, i.e. WIDTH cycles after acceptance.
  - Minimum spacing between accepted starts is WIDTH+2 cycles.
- Result: sum and c_out equal (a + b + c_in) as a (WIDTH+1)-bit value: c_out is the MSB, sum the low WIDTH bits. Inputs are unsigned; no overflow flag.
- Boundary conditions:
  - start while RUN or DONE: ignored; in-flight operation unaffected; no queuing.
  - start held high continuously: a new operation is accepted on each IDLE edge. Back-to-back period is WIDTH+2.
  - a, b, c_in changing after acceptance: no effect.
  - rst asserted mid-RUN: operation aborted; no done pulse; sum and c_out clear to 0.
  - rst and start both high: reset wins; start is not accepted.
  - WIDTH = 1: one RUN cycle; done is high 1 cycle after acceptance.
- sum and c_out change only on the completion edge (and on reset); they are stable at all other times.

Test Plan:
- Basic add, WIDTH=8, cell connected: a=0x5A, b=0x3C, c_in=0, start 1 cycle -> busy high 8 cycles, done pulses exactly 8 cycles after acceptance, sum=0x96, c_out=0; fa_p sequence LSB first 0,1,0,1,1,0,1,0.
- Carry ripple: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
- Start during busy: accept a=0x10, b=0x20; pulse start with a=0xAA, b=0x55 at cycle 3 of RUN -> only one done, sum=0x30, c_out=0; the second request is not executed.
- Reset mid-operation: accept a=0x0F, b=0x01; assert rst at cycle 4 of RUN -> next cycle state IDLE, busy=0, sum=0x00, c_out=0, no done pulse. New start afterwards computes correctly.
- Back-to-back and hold: start held high, operands 0x01+0x01 -> done every 10 cycles, sum=0x02 each time; sum held stable between pulses.
- Randomized self-check, WIDTH=8 and WIDTH=1: 500 random (a, b, c_in) -> {c_out, sum} matches the reference add on every done.
